// File: rtl/half_band_filter_mac.sv
// Symmetric half-band FIR with a single time-shared multiplier walking the nonzero
// coefficient pairs, run-time coefficient load, optional 2:1 decimation, round/saturate.
module half_band_filter_mac #(
    parameter int DW    = 18,
    parameter int CW    = 18,
    parameter int NP    = 3,
    parameter int DECIM = 1,
    localparam int AW   = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic signed [DW-1:0] x_in,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 overrun_clr,
    output logic signed [DW-1:0] y,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int N    = 4*NP - 1;
    localparam int C    = 2*NP - 1;
    localparam int PW   = DW + CW + 1;
    localparam int CNTW = $clog2(NP + 1);
    localparam int ACCW = PW + CNTW;

    localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] RND   = {{(ACCW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [CNTW-1:0]        cnt;
    logic                   phase;
    logic signed [DW-1:0]   d    [N];
    logic signed [CW-1:0]   coef [NP];

    logic signed [DW-1:0]   tap_a, tap_b;
    logic signed [CW-1:0]   coef_sel;
    logic signed [DW:0]     pre_sum;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc, centre, acc_rnd, acc_shr;
    logic signed [DW-1:0]   y_sat;

    logic sample_start, mac_step, out_fire, coef_wr_ok;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // A new sample always preempts whatever sequence is running
    always_comb begin
        state_nxt = state;
        if (clk_en) begin
            state_nxt = sample_start ? S_MAC : S_IDLE;
        end else begin
            unique case (state)
                S_MAC:   if (cnt == CNTW'(NP)) state_nxt = S_OUT;
                S_OUT:   state_nxt = S_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy         = (state != S_IDLE);
        sample_start = clk_en && ((DECIM != 2) || !phase);
        mac_step     = (state == S_MAC) && !clk_en;
        out_fire     = (state == S_OUT) && !clk_en;
        coef_wr_ok   = coef_we && !busy && ({1'b0, coef_addr} < (AW+1)'(NP));
    end

    // Pair k = cnt: taps mirrored about the centre at odd offsets 2k+1
    always_comb begin
        tap_a    = '0;
        tap_b    = '0;
        coef_sel = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (cnt == CNTW'(k)) begin
                tap_a    = d[C - 2*k - 1];
                tap_b    = d[C + 2*k + 1];
                coef_sel = coef[k];
            end
        end
        pre_sum = {tap_a[DW-1], tap_a} + {tap_b[DW-1], tap_b};
    end

    // Centre tap is fixed at 0.5; d[C-1] here becomes d[C] on the accepting edge
    always_comb begin
        centre  = ACCW'(d[C-1]) <<< (CW - 3);
        acc_rnd = acc + RND;
        acc_shr = acc_rnd >>> (CW - 2);
        if (acc_shr > Y_MAX)      y_sat = {1'b0, {(DW-1){1'b1}}};
        else if (acc_shr < Y_MIN) y_sat = {1'b1, {(DW-1){1'b0}}};
        else                      y_sat = acc_shr[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++)  d[i]    <= '0;
            for (int unsigned k = 0; k < NP; k++) coef[k] <= '0;
            phase   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            prod    <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (clk_en) begin
                d[0] <= x_in;
                for (int unsigned i = 1; i < N; i++) d[i] <= d[i-1];
                if (DECIM == 2) phase <= ~phase;
            end

            if (coef_wr_ok) coef[coef_addr] <= coef_data;

            if (clk_en)        cnt <= '0;
            else if (mac_step) cnt <= cnt + CNTW'(1);

            // Product of pair k lands one edge later, so accumulation lags by one step
            if (mac_step) prod <= PW'(pre_sum) * PW'(coef_sel);

            if (sample_start)                  acc <= centre;
            else if (mac_step && cnt != '0)    acc <= acc + ACCW'(prod);

            y_valid <= out_fire;
            if (out_fire) y <= y_sat;

            if (clk_en && busy)   overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_half_band_filter_mac.sv
// Scoreboard bench: a tap-level arithmetic model predicts each y and its cycle for a
// non-decimating and a 2:1 decimating instance sharing one stimulus stream.
module tb_half_band_filter_mac;

    localparam int DW = 18;
    localparam int CW = 18;
    localparam int NP = 3;
    localparam int N  = 4*NP - 1;
    localparam int C  = 2*NP - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clk_en;
    logic signed [DW-1:0] x_in;
    logic                 coef_we;
    logic [1:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 overrun_clr;
    logic signed [DW-1:0] y1, y2;
    logic                 y_valid1, y_valid2, busy1, busy2, overrun1, overrun2;

    always #5 clk = ~clk;

    half_band_filter_mac #(.DW(DW), .CW(CW), .NP(NP), .DECIM(1)) u_dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .overrun_clr(overrun_clr), .y(y1), .y_valid(y_valid1), .busy(busy1), .overrun(overrun1)
    );

    half_band_filter_mac #(.DW(DW), .CW(CW), .NP(NP), .DECIM(2)) u_dut2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .overrun_clr(overrun_clr), .y(y2), .y_valid(y_valid2), .busy(busy2), .overrun(overrun2)
    );

    typedef struct {
        logic signed [DW-1:0] y;
        int                   cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int n_valid2 = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, one slot per instance (0: DECIM=1, 1: DECIM=2)
    longint               md    [2][N];
    longint               mcoef [2][NP];
    bit                   mphase[2];
    bit                   mact  [2];
    bit                   mpend [2];
    bit                   movr  [2];
    int                   mstart[2];
    logic signed [DW-1:0] mexp  [2];

    function automatic logic signed [DW-1:0] ref_out(input int i);
        longint s;
        s = md[i][C] * 32768;
        for (int k = 0; k < NP; k++)
            s += mcoef[i][k] * (md[i][C-2*k-1] + md[i][C+2*k+1]);
        s = (s + 32768) >>> 16;
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        return DW'(s);
    endfunction

    function automatic bit mbusy(input int i, input int e);
        return mact[i] && (e >= mstart[i]) && (e < mstart[i] + NP + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < N; j++)  md[i][j]    = 0;
            for (int k = 0; k < NP; k++) mcoef[i][k] = 0;
            mphase[i] = 0; mact[i] = 0; mpend[i] = 0; movr[i] = 0; mstart[i] = 0;
        end
        q1.delete();
        q2.delete();
    endtask

    task automatic model_edge(input int i, input int t, input bit en, input int x, input bit we,
                              input int addr, input int data, input bit clr, input int gap);
        bit   bsy;
        bit   st;
        exp_t e;
        logic signed [DW-1:0] xs;
        logic signed [CW-1:0] cs;
        xs  = DW'(x);
        cs  = CW'(data);
        bsy = mbusy(i, t - 1);
        if (we && !bsy && addr < NP) mcoef[i][addr] = cs;
        if (en && bsy)  movr[i] = 1;
        else if (clr)   movr[i] = 0;
        if (en) begin
            if (bsy) mpend[i] = 0;
            for (int j = N - 1; j > 0; j--) md[i][j] = md[i][j-1];
            md[i][0] = xs;
            st = (i == 0) || !mphase[i];
            if (i == 1) mphase[i] = !mphase[i];
            if (st) begin
                mact[i] = 1; mstart[i] = t; mpend[i] = 1; mexp[i] = ref_out(i);
            end else begin
                mact[i] = 0; mpend[i] = 0;
            end
        end
        // Next possible clk_en is at t+gap; anything finishing before that is certain
        if (mpend[i] && (mstart[i] + NP + 2 < t + gap)) begin
            e.y   = mexp[i];
            e.cyc = mstart[i] + NP + 2;
            if (i == 0) q1.push_back(e);
            else        q2.push_back(e);
            mpend[i] = 0;
        end
    endtask

    // Called at a negedge; drives one edge of controls then idles gap-1 cycles
    task automatic drive(input bit en, input int x, input bit we, input int addr,
                         input int data, input bit clr, input int gap);
        int t;
        t = cyc + 1;
        for (int i = 0; i < 2; i++) model_edge(i, t, en, x, we, addr, data, clr, gap);
        clk_en      = en;
        x_in        = DW'(x);
        coef_we     = we;
        coef_addr   = 2'(addr);
        coef_data   = CW'(data);
        overrun_clr = clr;
        @(negedge clk);
        clk_en = 1'b0; coef_we = 1'b0; overrun_clr = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic check(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_busy1"},    longint'(busy1),    longint'(mbusy(0, cyc)));
        check({tag, "_busy2"},    longint'(busy2),    longint'(mbusy(1, cyc)));
        check({tag, "_overrun1"}, longint'(overrun1), longint'(movr[0]));
        check({tag, "_overrun2"}, longint'(overrun2), longint'(movr[1]));
    endtask

    task automatic load_coefs(input int c0, input int c1, input int c2);
        drive(0, 0, 1, 0, c0, 0, 1);
        drive(0, 0, 1, 1, c1, 0, 1);
        drive(0, 0, 1, 2, c2, 0, 1);
    endtask

    task automatic impulse();
        drive(1, 4096, 0, 0, 0, 0, 8);
        for (int j = 0; j < 11; j++) drive(1, 0, 0, 0, 0, 0, 8);
    endtask

    // Monitor: every y_valid pops one expectation and checks value and cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (y_valid1) begin
                n_tests++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL y1_unexpected: y=%0d at cycle %0d, required no y_valid", y1, cyc);
                end else begin
                    e = q1.pop_front();
                    if (y1 !== e.y || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL y1: y=%0d at cycle %0d, required y=%0d at cycle %0d", y1, cyc, e.y, e.cyc);
                    end
                end
            end
            if (y_valid2) begin
                n_valid2++;
                n_tests++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL y2_unexpected: y=%0d at cycle %0d, required no y_valid", y2, cyc);
                end else begin
                    e = q2.pop_front();
                    if (y2 !== e.y || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL y2: y=%0d at cycle %0d, required y=%0d at cycle %0d", y2, cyc, e.y, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b0; clk_en = 1'b0; x_in = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; overrun_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_y1", y1, 0);             check("rst_y2", y2, 0);
        check("rst_yv1", y_valid1, 0);      check("rst_yv2", y_valid2, 0);
        check("rst_busy1", busy1, 0);       check("rst_busy2", busy2, 0);
        check("rst_ovr1", overrun1, 0);     check("rst_ovr2", overrun2, 0);
        reset = 1'b1;
        @(negedge clk);

        // Impulse response
        load_coefs(16384, -4096, 2048);
        impulse();
        check_flags("impulse");

        // DC gain of one
        load_coefs(20480, -4096, 0);
        for (int j = 0; j < 14; j++) drive(1, 10000, 0, 0, 0, 0, 8);
        check("dc_settled_y1", y1, 10000);

        // Coefficient write on the same edge as the sample
        drive(1, 3000, 1, 2, 1000, 0, 8);
        for (int j = 0; j < 3; j++) drive(1, -7000, 0, 0, 0, 0, 8);

        // Saturation both ways
        load_coefs(131071, 131071, 131071);
        for (int j = 0; j < 12; j++) drive(1, 131071, 0, 0, 0, 0, 8);
        check("sat_pos_y1", y1, 131071);
        for (int j = 0; j < 12; j++) drive(1, -131072, 0, 0, 0, 0, 8);
        check("sat_neg_y1", y1, -131072);

        // Randomised traffic: random samples, spacing, coefficient writes
        for (int j = 0; j < 80; j++) begin
            if ($urandom_range(0, 4) == 0)
                drive(0, 0, 1, $urandom_range(0, 3), $urandom, 0, $urandom_range(1, 3));
            else
                drive(1, $urandom, ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                      $urandom, ($urandom_range(0, 7) == 0), $urandom_range(2, 9));
        end
        drive(0, 0, 0, 0, 0, 0, 10);
        check_flags("random");

        // Overrun: spacing 3 aborts, clear coincident with new overrun keeps it set
        load_coefs(16384, -4096, 2048);
        drive(0, 0, 0, 0, 0, 1, 2);
        check_flags("ovr_cleared");
        for (int j = 0; j < 6; j++) drive(1, 1000 * (j + 1), 0, 0, 0, 0, 3);
        check_flags("ovr_set");
        drive(1, 5000, 0, 0, 0, 1, 3);
        check_flags("ovr_clr_vs_set");
        drive(1, -2000, 0, 0, 0, 0, 8);
        check_flags("ovr_hold");
        drive(0, 0, 0, 0, 0, 1, 2);
        check_flags("ovr_clr");

        // Guarded writes: out-of-range address and write while busy are ignored
        for (int j = 0; j < 12; j++) drive(1, 0, 0, 0, 0, 0, 8);
        drive(0, 0, 1, 3, 9999, 0, 1);
        drive(1, 4096, 0, 0, 0, 0, 2);
        drive(0, 0, 1, 0, 5555, 0, 6);
        check_flags("guard");
        for (int j = 0; j < 11; j++) drive(1, 0, 0, 0, 0, 0, 8);

        // Async reset in the middle of a MAC
        drive(1, 4096, 0, 0, 0, 0, 2);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rstmid_y1", y1, 0);          check("rstmid_busy1", busy1, 0);
        check("rstmid_yv1", y_valid1, 0);   check("rstmid_y2", y2, 0);
        check("rstmid_busy2", busy2, 0);    check("rstmid_ovr1", overrun1, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        impulse();

        // Decimation: ten samples give five outputs on the 2:1 instance
        base = n_valid2;
        for (int j = 0; j < 10; j++) drive(1, 500 * (j + 1), 0, 0, 0, 0, 8);
        drive(0, 0, 0, 0, 0, 0, 10);
        check("decim_count", n_valid2 - base, 5);

        repeat (10) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
